// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, start/done handshake.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the iterations and raises dbz.
module seq_restoring_divider #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         dbz,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is only looked at in IDLE; busy is high in RUN;
  // done is a one-cycle pulse in DONE, where the result outputs first show the new values.
  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_dvd;
  logic [D-1:0]   r_dvd_lo;
  logic [D-1:0]   r_dvs;
  logic           r_zero;
  logic [D-1:0]   r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_q_out;
  logic [D-1:0]   r_r_out;

  logic           w_accept;
  logic           w_zero_in;
  logic           w_last;
  logic [D:0]     w_t;
  logic           w_ge;
  logic [D:0]     w_r_next;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_zero_in = (divisor == '0);
  assign w_last    = (r_cnt == '0);

  // The partial remainder stays below the divisor, so only its low D bits are stored;
  // the trial value carries the extra top bit.
  assign w_t      = {r_rem, r_dvd[N-1]};
  assign w_ge     = (w_t >= {1'b0, r_dvs});
  assign w_r_next = w_ge ? (w_t - {1'b0, r_dvs}) : w_t;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = w_zero_in ? S_DONE : S_RUN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvd_lo <= '0;
      r_dvs    <= '0;
      r_zero   <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_q_out  <= '0;
      r_r_out  <= '0;
    end else if (w_accept) begin
      r_dvd    <= dividend;
      r_dvd_lo <= dividend[D-1:0];
      r_dvs    <= divisor;
      r_zero   <= w_zero_in;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= CW'(N);
`ifdef DIV_ZERO_FAST_EN
      if (w_zero_in) begin
        r_q_out <= '1;
        r_r_out <= dividend[D-1:0];
      end
`endif
    end else if (r_state == S_RUN) begin
      if (!w_last) begin
        r_rem <= w_r_next[D-1:0];
        r_quo <= {r_quo[N-2:0], w_ge};
        r_dvd <= {r_dvd[N-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
      end else if (r_zero) begin
        // Divide-by-zero results are forced rather than taken from the iteration.
        r_q_out <= '1;
        r_r_out <= r_dvd_lo;
      end else begin
        r_q_out <= r_quo;
        r_r_out <= r_rem;
      end
    end
  end

`ifdef DIV_ZERO_FAST_EN
  logic r_dbz;
  always_ff @(posedge clk) begin
    if (!rst_n)        r_dbz <= 1'b0;
    else if (w_accept) r_dbz <= w_zero_in;
  end
  assign dbz = r_dbz && (r_state != S_RUN);
`else
  assign dbz = 1'b0;
`endif

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_q_out;
  assign remainder = r_r_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: scoreboard queue of expected {quotient, remainder}.
module tb_seq_restoring_divider;
  localparam int N = 8;
  localparam int D = 4;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         dbz;
  logic [1:0]   dbg_state;

  seq_restoring_divider #(.N(N), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .dbz(dbz), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N+D-1:0] exp_q[$];
  logic [N-1:0]   last_q;
  logic [D-1:0]   last_r;
  logic           last_dbz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [N-1:0] dvd, input logic [D-1:0] dvs);
    logic [N-1:0] q;
    logic [D-1:0] r;
    if (dvs == '0) begin
      q = '1;
      r = dvd[D-1:0];
    end else begin
      q = dvd / N'(dvs);
      r = D'(dvd % N'(dvs));
    end
    exp_q.push_back({q, r});
  endtask

  task automatic run_div(input logic [N-1:0] dvd, input logic [D-1:0] dvs, input bit interfere);
    int lat;
    int cyc;
    bit seen;
    bit exp_dbz;
    logic [N+D-1:0] e;
    lat = (FAST && dvs == '0) ? 1 : N + 2;
    exp_dbz = FAST && (dvs == '0);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    push_exp(dvd, dvs);
    step();
    start    = 1'b0;
    dividend = N'($urandom_range(0, 255));
    divisor  = D'($urandom_range(0, 15));
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= N + 4) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("busy_run", busy, 1);
      chk("hold_q_run", quotient, last_q);
      chk("hold_r_run", remainder, last_r);
      chk("dbz_run", dbz, 0);
      if (interfere && cyc == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", cyc, lat);
    e = exp_q.pop_front();
    if (seen) begin
      chk("quotient", quotient, e[N+D-1:D]);
      chk("remainder", remainder, e[D-1:0]);
      chk("busy_done", busy, 0);
      chk("dbz_done", dbz, exp_dbz);
    end
    last_q   = e[N+D-1:D];
    last_r   = e[D-1:0];
    last_dbz = exp_dbz;
    step();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("hold_q_idle", quotient, last_q);
    chk("hold_r_idle", remainder, last_r);
    chk("hold_dbz_idle", dbz, last_dbz);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;
    last_r   = '0;
    last_dbz = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    run_div(8'd200, 4'd7, 1'b0);

    // Results must hold while the operand inputs wander without a start.
    for (int i = 0; i < 20; i++) begin
      dividend = N'($urandom_range(0, 255));
      divisor  = D'($urandom_range(0, 15));
      step();
      chk("hold_q", quotient, 28);
      chk("hold_r", remainder, 4);
      chk("hold_done", done, 0);
    end

    run_div(8'd255, 4'd1, 1'b0);
    run_div(8'd255, 4'd15, 1'b0);
    run_div(8'd5, 4'd9, 1'b0);
    run_div(8'd0, 4'd3, 1'b0);
    run_div(8'd100, 4'd3, 1'b1);
    run_div(8'hA7, 4'd0, 1'b0);
    run_div(8'd13, 4'd4, 1'b0);

    // Reset in the middle of a division.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", dbz, 0);
    chk("midrst_state", dbg_state, 0);
    rst_n = 1'b1;
    last_q   = '0;
    last_r   = '0;
    last_dbz = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      step();
      chk("midrst_no_done", done, 0);
      chk("midrst_idle_busy", busy, 0);
    end

    run_div(8'd9, 4'd2, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_div(N'($urandom_range(0, 255)), D'($urandom_range(0, 15)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
